// File: rtl/key_debouncer.sv
// Purpose: per-key 2-flop synchroniser plus debounce FSM for active-low push-buttons; emits a press pulse and a clean level.
// Latency: o_pulse/o_level change DEB_CYCLES+2 edges after the first edge that samples a stable new key state.
// Backpressure: none; free-running, outputs registered. Optional auto-repeat via `define KEY_AUTOREPEAT_EN.
module key_debouncer #(
    parameter int NUM_KEYS      = 4,
    parameter int DEB_CYCLES    = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_pulse,
    output logic [NUM_KEYS-1:0] o_level
);

    localparam int MAX_A   = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_PWAIT, S_PRESSED, S_RWAIT} state_t;

    localparam cnt_t DEB_LAST = cnt_t'(DEB_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t REP_LAST  = cnt_t'(REPEAT_CYCLES - 1);
`endif

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    state_t              state     [NUM_KEYS];
    state_t              state_nxt [NUM_KEYS];
    cnt_t                cnt       [NUM_KEYS];
    cnt_t                cnt_nxt   [NUM_KEYS];
    logic [NUM_KEYS-1:0] pulse_nxt;
    logic [NUM_KEYS-1:0] level_nxt;
`ifdef KEY_AUTOREPEAT_EN
    // Set once the initial hold pulse has fired; later pulses use the repeat period.
    logic [NUM_KEYS-1:0] rep;
    logic [NUM_KEYS-1:0] rep_nxt;
`endif

    // Two-flop synchroniser; idles released (1) so reset never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= i_key_n;
            sync2 <= sync1;
        end
    end

    // Per-key state, stability counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state[k] <= S_IDLE;
                cnt[k]   <= '0;
            end
            o_pulse <= '0;
            o_level <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state[k] <= state_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
            o_pulse <= pulse_nxt;
            o_level <= level_nxt;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    // Hold/repeat phase flag, cleared whenever a key leaves S_PRESSED.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep <= '0;
        end else begin
            rep <= rep_nxt;
        end
    end
`endif

    // Next-state logic: debounce windows on press and release, pulse only on entry to S_PRESSED.
    always_comb begin
        pulse_nxt = '0;
        level_nxt = '0;
`ifdef KEY_AUTOREPEAT_EN
        rep_nxt   = '0;
`endif
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_nxt[k] = state[k];
            cnt_nxt[k]   = cnt[k];
            case (state[k])
                S_IDLE: begin
                    if (!sync2[k]) begin
                        state_nxt[k] = S_PWAIT;
                        cnt_nxt[k]   = cnt_t'(1);
                    end
                end
                S_PWAIT: begin
                    if (sync2[k]) begin
                        state_nxt[k] = S_IDLE;
                        cnt_nxt[k]   = '0;
                    end else if (cnt[k] == DEB_LAST) begin
                        state_nxt[k] = S_PRESSED;
                        cnt_nxt[k]   = '0;
                        pulse_nxt[k] = 1'b1;
                    end else begin
                        cnt_nxt[k] = cnt[k] + cnt_t'(1);
                    end
                end
                S_PRESSED: begin
                    if (sync2[k]) begin
                        state_nxt[k] = S_RWAIT;
                        cnt_nxt[k]   = cnt_t'(1);
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        rep_nxt[k] = rep[k];
                        if (!rep[k] && cnt[k] == HOLD_LAST) begin
                            pulse_nxt[k] = 1'b1;
                            cnt_nxt[k]   = '0;
                            rep_nxt[k]   = 1'b1;
                        end else if (rep[k] && cnt[k] == REP_LAST) begin
                            pulse_nxt[k] = 1'b1;
                            cnt_nxt[k]   = '0;
                        end else begin
                            cnt_nxt[k] = cnt[k] + cnt_t'(1);
                        end
`else
                        cnt_nxt[k] = '0;
`endif
                    end
                end
                S_RWAIT: begin
                    if (!sync2[k]) begin
                        state_nxt[k] = S_PRESSED;
                        cnt_nxt[k]   = '0;
                    end else if (cnt[k] == DEB_LAST) begin
                        state_nxt[k] = S_IDLE;
                        cnt_nxt[k]   = '0;
                    end else begin
                        cnt_nxt[k] = cnt[k] + cnt_t'(1);
                    end
                end
                default: begin
                    state_nxt[k] = S_IDLE;
                    cnt_nxt[k]   = '0;
                end
            endcase
            level_nxt[k] = (state_nxt[k] == S_PRESSED) || (state_nxt[k] == S_RWAIT);
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer with DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
// Directed scenarios check fixed edge numbers; a random phase checks against a run-length reference model.
// Define KEY_AUTOREPEAT_EN for both bench and RTL to exercise the auto-repeat build.
module tb_key_debouncer;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [3:0] o_pulse;
    logic [3:0] o_level;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: sync history, run length of samples opposing the level, age in pressed.
    bit [3:0] m_sh1, m_sh2, m_level, m_pulse;
    int       m_run [4];
    int       m_age [4];

    key_debouncer #(
        .NUM_KEYS     (4),
        .DEB_CYCLES   (DEB),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_key_n(key_n),
        .o_pulse(o_pulse),
        .o_level(o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_sh1   = '1;
        m_sh2   = '1;
        m_level = '0;
        m_pulse = '0;
        for (int k = 0; k < 4; k++) begin
            m_run[k] = 0;
            m_age[k] = 0;
        end
    endtask

    // A level flips after DEB consecutive synchronised samples disagreeing with it.
    task automatic model_step();
        bit s;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_pulse = '0;
            for (int k = 0; k < 4; k++) begin
                s        = m_sh2[k];
                m_sh2[k] = m_sh1[k];
                m_sh1[k] = key_n[k];
                if (!m_level[k]) begin
                    if (!s) begin
                        m_run[k]++;
                        if (m_run[k] == DEB) begin
                            m_level[k] = 1'b1;
                            m_pulse[k] = 1'b1;
                            m_run[k]   = 0;
                            m_age[k]   = 0;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end else if (s) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_level[k] = 1'b0;
                        m_run[k]   = 0;
                    end
                end else if (m_run[k] > 0) begin
                    m_run[k] = 0;
                    m_age[k] = 0;
                end else begin
                    m_age[k]++;
                    if (AR && (m_age[k] == HOLD ||
                               (m_age[k] > HOLD && (m_age[k] - HOLD) % REP == 0)))
                        m_pulse[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle(input int n);
        key_n = 4'b1111;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 4'b1111;
        model_reset();
        #2;
        n_checks++;
        if ({o_pulse, o_level} !== 8'h00)
            $display("FAIL reset_async: got %b want %b", {o_pulse, o_level}, 8'h00);
        else n_pass++;
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_checks++;
            if ({o_pulse, o_level} !== 8'h00)
                $display("FAIL reset_hold edge %0d: got %b want %b", e, {o_pulse, o_level}, 8'h00);
            else n_pass++;
        end
        rst_n = 1'b1;
        settle(4);
    endtask

    task automatic test_clean_press();
        logic [7:0] exp;
        key_n = 4'b1110;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp = 8'h00;
            if (e == 6 || (AR && e == 26)) exp[4] = 1'b1;
            if (e >= 6) exp[0] = 1'b1;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL clean_press edge %0d: got %b want %b", e, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        key_n = 4'b1111;
        for (int r = 1; r <= 8; r++) begin
            tick();
            exp = (r < 6) ? 8'h01 : 8'h00;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL clean_release edge %0d: got %b want %b", r, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        settle(4);
    endtask

    task automatic test_press_bounce();
        logic [7:0] exp;
        for (int e = 1; e <= 20; e++) begin
            key_n = {2'b11, (e == 4 || e == 8), 1'b1};
            tick();
            exp = 8'h00;
            if (e == 14) exp[5] = 1'b1;
            if (e >= 14) exp[1] = 1'b1;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL press_bounce edge %0d: got %b want %b", e, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        settle(10);
    endtask

    task automatic test_release_bounce();
        logic [7:0] exp;
        key_n = 4'b1011;
        repeat (10) tick();
        for (int r = 1; r <= 14; r++) begin
            key_n = {1'b1, (r != 3), 2'b11};
            tick();
            exp = (r < 9) ? 8'h04 : 8'h00;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL release_bounce edge %0d: got %b want %b", r, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        settle(4);
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        key_n = 4'b0110;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp = 8'h00;
            if (e == 6) exp[7:4] = 4'b1001;
            if (e >= 6) exp[3:0] = 4'b1001;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL simultaneous edge %0d: got %b want %b", e, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        settle(10);
    endtask

    task automatic test_reset_mid_count();
        logic [7:0] exp;
        key_n = 4'b1110;
        for (int e = 1; e <= 3; e++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({o_pulse, o_level} !== 8'h00)
            $display("FAIL reset_mid_async: got %b want %b", {o_pulse, o_level}, 8'h00);
        else n_pass++;
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_checks++;
            if ({o_pulse, o_level} !== 8'h00)
                $display("FAIL reset_mid_hold edge %0d: got %b want %b", e, {o_pulse, o_level}, 8'h00);
            else n_pass++;
        end
        rst_n = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            tick();
            exp = 8'h00;
            if (r == 6) exp[4] = 1'b1;
            if (r >= 6) exp[0] = 1'b1;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL reset_mid_press edge %0d: got %b want %b", r, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        settle(10);
    endtask

    task automatic test_autorepeat();
        logic [7:0] exp;
        key_n = 4'b1011;
        for (int e = 1; e <= 60; e++) begin
            tick();
            exp = 8'h00;
            if (e == 6 || (AR && e >= 26 && (e - 26) % 8 == 0)) exp[6] = 1'b1;
            if (e >= 6) exp[2] = 1'b1;
            n_checks++;
            if ({o_pulse, o_level} !== exp)
                $display("FAIL autorepeat edge %0d: got %b want %b", e, {o_pulse, o_level}, exp);
            else n_pass++;
        end
        settle(10);
    endtask

    task automatic test_random();
        int left [4];
        for (int k = 0; k < 4; k++) left[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (left[k] == 0) begin
                    key_n[k] = 1'($urandom_range(0, 1));
                    left[k]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 60))
                                                           : int'($urandom_range(1, 5));
                end else begin
                    left[k]--;
                end
            end
            if (c == 1500) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (c == 1503) rst_n = 1'b1;
            tick();
            n_checks++;
            if ({o_pulse, o_level} !== {m_pulse, m_level})
                $display("FAIL random cycle %0d: got %b want %b", c, {o_pulse, o_level}, {m_pulse, m_level});
            else n_pass++;
        end
        settle(10);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 4'b1111;
        model_reset();
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
